// File: rtl/lane_scheduler_pkg.sv
// Shared constants, coordinate type and FSM encodings for the lane scheduler.
package lane_scheduler_pkg;

   localparam int LANES    = 4;
   localparam int COORD_W  = 6;
   localparam int PERIOD_W = 4;

   typedef logic [COORD_W-1:0] coord_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic coord_t lane_field(input logic [LANES*COORD_W-1:0] vec, input int k);
      return vec[k*COORD_W +: COORD_W];
   endfunction

endpackage

// File: rtl/lane_scheduler_if.sv
// Game-side bundle of the lane scheduler: run control, frog position, lane state out.
interface lane_scheduler_if;
   import lane_scheduler_pkg::*;

   logic                     i_Enable;
   coord_t                   i_Frog_X;
   coord_t                   i_Frog_Y;
   logic [LANES*COORD_W-1:0] o_Lane_X;
   logic                     o_Frog_Push;
   logic                     o_Frog_Dir;
   logic                     o_Update_Valid;

   modport master (
      output i_Enable, i_Frog_X, i_Frog_Y,
      input  o_Lane_X, o_Frog_Push, o_Frog_Dir, o_Update_Valid
   );

   modport slave (
      input  i_Enable, i_Frog_X, i_Frog_Y,
      output o_Lane_X, o_Frog_Push, o_Frog_Dir, o_Update_Valid
   );

endinterface

// File: rtl/lane_scheduler_tick_gen.sv
// Base movement divider: counts enabled cycles and flags the terminal count.
module tick_gen #(
   parameter int c_TICK_COUNT = 1250000
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Enable,
   output logic o_Tick
);

   localparam int CW = $clog2(c_TICK_COUNT);
   localparam logic [CW-1:0] LAST = CW'(c_TICK_COUNT - 1);

   logic [CW-1:0] count;

   assign o_Tick = i_Enable && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_Clk) begin
      if (i_Reset)
         count <= '0;
      else if (i_Enable)
         count <= o_Tick ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/lane_scheduler.sv
// Sweeps the four lanes one per cycle on each movement tick through one shared step/compare path.
module lane_scheduler
   import lane_scheduler_pkg::*;
#(
   parameter int                       c_TICK_COUNT = 1250000,
   parameter int                       c_GRID_W     = 20,
   parameter int                       c_LOG_LEN    = 3,
   parameter logic [LANES*COORD_W-1:0] c_LANE_ROWS  = {6'd4, 6'd5, 6'd6, 6'd7},
   parameter logic [LANES*PERIOD_W-1:0] c_PERIODS   = {4'd1, 4'd3, 4'd2, 4'd4},
   parameter logic [LANES-1:0]         c_DIRS       = 4'b0101,
   parameter logic [LANES*COORD_W-1:0] c_INIT_X     = {6'd0, 6'd13, 6'd7, 6'd2}
) (
   input logic             i_Clk,
   input logic             i_Reset,
   lane_scheduler_if.slave bus
);

   logic                tick;
   logic [1:0]          state;
   logic                pending;
   logic [1:0]          lane_idx;
   logic [PERIOD_W-1:0] period_cnt [LANES];
   coord_t              lane_x     [LANES];

   coord_t              x_old, x_stepped, row;
   logic                dir, at_edge, step, in_log, push;
   logic [PERIOD_W-1:0] cnt_cur, reload;

   tick_gen #(.c_TICK_COUNT(c_TICK_COUNT)) u_tick_gen (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Enable (bus.i_Enable),
      .o_Tick   (tick)
   );

   // Single datapath: every operand is selected by the lane currently being serviced.
   // NOTE: each always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      x_old     = lane_x[lane_idx];
      row       = lane_field(c_LANE_ROWS, int'(lane_idx));
      dir       = c_DIRS[lane_idx];
      cnt_cur   = period_cnt[lane_idx];
      reload    = c_PERIODS[lane_idx*PERIOD_W +: PERIOD_W] - 4'd1;
      step      = (state == ST_SWEEP) && (cnt_cur == '0);
      at_edge   = dir ? (x_old == coord_t'(c_GRID_W - 1)) : (x_old == '0);
      x_stepped = at_edge ? (dir ? '0 : coord_t'(c_GRID_W - 1))
                          : x_old + (dir ? coord_t'(1) : '1);
      in_log    = ({1'b0, bus.i_Frog_X} >= {1'b0, x_old}) &&
                  ({1'b0, bus.i_Frog_X} <= {1'b0, x_old} + 7'(c_LOG_LEN - 1));
      push      = step && (bus.i_Frog_Y == row) && in_log;
   end

   always_comb begin
      bus.o_Lane_X = '0;
      for (int k = 0; k < LANES; k++)
         bus.o_Lane_X[k*COORD_W +: COORD_W] = lane_x[k];
   end

   assign bus.o_Frog_Push    = push;
   assign bus.o_Frog_Dir     = push & dir;
   assign bus.o_Update_Valid = (state == ST_DONE);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state    <= ST_IDLE;
         pending  <= 1'b0;
         lane_idx <= '0;
         // NOTE: the per-lane arrays are tiny register files, so they are reset explicitly.
         for (int k = 0; k < LANES; k++) begin
            period_cnt[k] <= c_PERIODS[k*PERIOD_W +: PERIOD_W] - 4'd1;
            lane_x[k]     <= c_INIT_X[k*COORD_W +: COORD_W];
         end
      end else begin
         if (state == ST_IDLE && pending)
            pending <= 1'b0;
         else if (tick)
            pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (pending) begin
                  state    <= ST_SWEEP;
                  lane_idx <= '0;
               end
            end
            ST_SWEEP: begin
               if (step) begin
                  period_cnt[lane_idx] <= reload;
                  lane_x[lane_idx]     <= x_stepped;
               end else begin
                  period_cnt[lane_idx] <= cnt_cur - 4'd1;
               end
               lane_idx <= lane_idx + 2'd1;
               if (lane_idx == 2'd3)
                  state <= ST_DONE;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench: stimulus queues expected sweep results and pushes, a monitor checks them.
module tb_lane_scheduler;
   import lane_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   lane_scheduler_if bus ();

   lane_scheduler #(
      .c_TICK_COUNT (8),
      .c_LANE_ROWS  ({6'd7, 6'd6, 6'd5, 6'd4}),
      .c_DIRS       (4'b0110)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lane configuration as seen by this bench (lanes 0..3).
   int init_x [4] = '{2, 7, 13, 0};
   int period [4] = '{4, 2, 3, 1};
   int dirs   [4] = '{0, 1, 1, 0};
   int rows   [4] = '{4, 5, 6, 7};

   typedef struct { int cyc; logic [23:0] x; } upd_t;
   typedef struct { int cyc; logic dir; } push_t;
   upd_t  upd_q[$];
   push_t push_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int pos(input int k, input int s);
      int n = s / period[k];
      return dirs[k] != 0 ? (init_x[k] + n) % 20 : ((init_x[k] - n) % 20 + 20) % 20;
   endfunction

   function automatic logic [23:0] exp_x(input int s);
      logic [23:0] r = '0;
      for (int k = 0; k < 4; k++) r[k*6 +: 6] = 6'(pos(k, s));
      return r;
   endfunction

   // Expected outcome of sweep s whose tick falls in cycle t.
   task automatic expect_sweep(input int s, input int t, input int fx, input int fy);
      for (int k = 0; k < 4; k++) begin
         if (s % period[k] == 0) begin
            int old = pos(k, s - 1);
            if (fy == rows[k] && fx >= old && fx <= old + 2)
               push_q.push_back('{cyc: t + 2 + k, dir: dirs[k][0]});
         end
      end
      upd_q.push_back('{cyc: t + 6, x: exp_x(s)});
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_Enable = 1'b0;
      wait_until(cyc + 2);
      rst = 1'b0;
   endtask

   initial begin : monitor
      upd_t  u;
      push_t p;
      forever begin
         @(negedge clk);
         if (bus.o_Update_Valid) begin
            if (upd_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_update: pulse seen at cycle %0d, required none", cyc);
            end else begin
               u = upd_q.pop_front();
               check("update_cycle", cyc, u.cyc);
               check("update_lane_x", {8'd0, bus.o_Lane_X}, {8'd0, u.x});
            end
         end
         if (bus.o_Frog_Push) begin
            if (push_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_push: pulse seen at cycle %0d, required none", cyc);
            end else begin
               p = push_q.pop_front();
               check("push_cycle", cyc, p.cyc);
               check("push_dir", {31'd0, bus.o_Frog_Dir}, {31'd0, p.dir});
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int c0, c1;
      bus.i_Enable = 1'b0;
      bus.i_Frog_X = 6'd5;
      bus.i_Frog_Y = 6'd4;
      @(posedge clk);
      #1;

      // Reset state, then four sweeps with frog just past the log: no push.
      do_reset();
      check("reset_lane_x", {8'd0, bus.o_Lane_X}, {8'd0, 6'd0, 6'd13, 6'd7, 6'd2});
      check("reset_push", {31'd0, bus.o_Frog_Push}, 32'd0);
      check("reset_update", {31'd0, bus.o_Update_Valid}, 32'd0);
      bus.i_Enable = 1'b1;
      c0 = cyc;
      for (int s = 1; s <= 4; s++) expect_sweep(s, c0 + 7 + 8 * (s - 1), 5, 4);
      wait_until(c0 + 22);
      check("lane0_after_sweep2", {26'd0, bus.o_Lane_X[5:0]}, 32'd2);
      wait_until(c0 + 38);
      check("lane0_after_sweep4", {26'd0, bus.o_Lane_X[5:0]}, 32'd1);

      // Frog on lane 0's log for 21 sweeps: pushes, left wrap 0->19, right wrap 19->0.
      bus.i_Frog_X = 6'd3;
      do_reset();
      bus.i_Enable = 1'b1;
      c0 = cyc;
      for (int s = 1; s <= 21; s++) expect_sweep(s, c0 + 7 + 8 * (s - 1), 3, 4);
      wait_until(c0 + 22);
      check("lane1_after_sweep2", {26'd0, bus.o_Lane_X[11:6]}, 32'd8);
      wait_until(c0 + 102);
      check("lane0_wrap_left", {26'd0, bus.o_Lane_X[5:0]}, 32'd19);
      wait_until(c0 + 150);
      check("lane2_before_wrap", {26'd0, bus.o_Lane_X[17:12]}, 32'd19);
      wait_until(c0 + 174);
      check("lane2_wrap_right", {26'd0, bus.o_Lane_X[17:12]}, 32'd0);

      // Enable drops during lane-1 service of sweep 3: sweep completes, counter holds.
      bus.i_Frog_X = 6'd0;
      bus.i_Frog_Y = 6'd0;
      do_reset();
      bus.i_Enable = 1'b1;
      c0 = cyc;
      for (int s = 1; s <= 3; s++) expect_sweep(s, c0 + 7 + 8 * (s - 1), 0, 0);
      wait_until(c0 + 26);
      bus.i_Enable = 1'b0;
      wait_until(c0 + 40);
      check("hold_lane_x", {8'd0, bus.o_Lane_X}, {8'd0, 6'd17, 6'd14, 6'd8, 6'd2});
      wait_until(c0 + 50);
      bus.i_Enable = 1'b1;
      c1 = cyc;
      expect_sweep(4, c1 + 5, 0, 0);
      wait_until(c1 + 12);

      // Reset during lane-2 service of sweep 2: partial sweep discarded, fresh start.
      do_reset();
      bus.i_Enable = 1'b1;
      c0 = cyc;
      expect_sweep(1, c0 + 7, 0, 0);
      wait_until(c0 + 19);
      rst = 1'b1;
      wait_until(c0 + 20);
      rst = 1'b0;
      check("mid_sweep_reset_lane_x", {8'd0, bus.o_Lane_X}, {8'd0, 6'd0, 6'd13, 6'd7, 6'd2});
      c1 = cyc;
      expect_sweep(1, c1 + 7, 0, 0);
      wait_until(c1 + 16);

      check("updates_outstanding", upd_q.size(), 32'd0);
      check("pushes_outstanding", push_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
